// File: rtl/proc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | proc_pkg: opcodes, state encoding and write-select codes.     |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package proc_pkg;

  localparam logic [1:0] OP_OUT = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_HALT   = ST_HALT
  } state_e;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_IMM = 2'd1;

  function automatic logic [1:0] opcode_of(input logic [7:0] instr);
    return instr[7:6];
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | proc_sequencer_if: ROM fetch bus plus regfile/result strobes. |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
interface proc_sequencer_if #(
  parameter int unsigned PC_W = 3
);
  logic [PC_W-1:0] address;
  logic [7:0]      instruction;
  logic [7:0]      ir;
  logic            rf_we;
  logic [1:0]      rf_wsel;
  logic [1:0]      rf_waddr;
  logic            result_load;

  modport master (
    output address, ir, rf_we, rf_wsel, rf_waddr, result_load,
    input  instruction
  );

  modport slave (
    input  address, ir, rf_we, rf_wsel, rf_waddr, result_load,
    output instruction
  );
endinterface
`default_nettype wire

// File: rtl/proc_sequencer_tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tick_prescaler: one-cycle tick every TICK_DIV clocks.         |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 30000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam logic [31:0] LAST = 32'(TICK_DIV - 1);

  logic [31:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = tick ? 32'd0 : count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= 32'd0;
    else      count_q <= count_d;
  end
endmodule
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | proc_sequencer: prescaled FETCH/DECODE/EXEC/HALT control FSM. |
// | PROC_SEQ_SINGLE_STEP_EN adds a `step` input.  Rev 1.0         |
// +--------------------------------------------------------------+
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned TICK_DIV = 30000000,
  parameter int unsigned PC_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef PROC_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  proc_sequencer_if.master bus,
  output logic [2:0]       state,
  output logic             halted
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [1:0]      op;
  logic            tick_raw, tick;
  logic            exec_we, exec_load;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_raw)
  );

`ifdef PROC_SEQ_SINGLE_STEP_EN
  logic step_q, stepping_q, stepping_d, step_rise;
  assign step_rise = step & ~step_q;
  // A stepped instruction runs at full clock rate regardless of the prescaler.
  assign tick = tick_raw | stepping_q;
`else
  assign tick = tick_raw;
`endif

  assign op = opcode_of(ir_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    exec_we   = 1'b0;
    exec_load = 1'b0;
`ifdef PROC_SEQ_SINGLE_STEP_EN
    stepping_d = stepping_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick && run) begin
          state_d = S_FETCH;
        end
`ifdef PROC_SEQ_SINGLE_STEP_EN
        else if (!run && step_rise) begin
          state_d    = S_FETCH;
          stepping_d = 1'b1;
        end
`endif
      end
      S_FETCH: if (tick) state_d = S_DECODE;
      S_DECODE: begin
        if (tick) begin
          ir_d    = bus.instruction;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (tick) begin
          exec_we   = (op == OP_ADD) || (op == OP_LDI);
          exec_load = (op == OP_OUT);
`ifdef PROC_SEQ_SINGLE_STEP_EN
          stepping_d = 1'b0;
`endif
          if (op == OP_JMP && ir_q[5]) begin
            state_d = S_HALT;
          end else begin
            pc_d    = (op == OP_JMP) ? ir_q[PC_W-1:0] : pc_q + 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_IDLE;
`ifdef PROC_SEQ_SINGLE_STEP_EN
        stepping_d = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 8'd0;
`ifdef PROC_SEQ_SINGLE_STEP_EN
      step_q     <= 1'b0;
      stepping_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef PROC_SEQ_SINGLE_STEP_EN
      step_q     <= step;
      stepping_q <= stepping_d;
`endif
    end
  end

  assign bus.address     = pc_q;
  assign bus.ir          = ir_q;
  assign bus.rf_we       = exec_we;
  assign bus.result_load = exec_load;
  assign bus.rf_wsel     = (op == OP_LDI) ? WSEL_IMM : WSEL_ALU;
  assign bus.rf_waddr    = (op == OP_LDI) ? ir_q[1:0] : ir_q[3:2];
  assign state           = state_q;
  assign halted          = (state_q == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_proc_sequencer: scoreboard bench, TICK_DIV=1 and =4 DUTs.  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tb_proc_sequencer;
  localparam int F_STATE = 0;
  localparam int F_ADDR  = 1;
  localparam int F_HALT  = 2;
  localparam int F_IR    = 3;

  typedef struct {
    bit         dut;
    int         cyc;
    bit         load;
    logic [1:0] waddr;
    logic [1:0] wsel;
    logic [2:0] addr;
  } ev_t;

  typedef struct {
    bit         dut;
    int         cyc;
    int         field;
    logic [7:0] val;
  } probe_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic       run_a = 1'b0, run_b = 1'b0;
  logic [2:0] state_a, state_b;
  logic       halted_a, halted_b;
  logic [7:0] rom_a [8];
  logic [7:0] rom_b [8];
  int         cyc_a = 0, cyc_b = 0;
  int         total = 0, bad = 0;
  bit         done = 1'b0, finished = 1'b0;
  ev_t        eq[$];
  probe_t     pq[$];
`ifdef PROC_SEQ_SINGLE_STEP_EN
  logic       step_a = 1'b0, step_b = 1'b0;
`endif

  proc_sequencer_if #(.PC_W(3)) ifa ();
  proc_sequencer_if #(.PC_W(3)) ifb ();

  proc_sequencer #(.TICK_DIV(1), .PC_W(3)) dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .run    (run_a),
`ifdef PROC_SEQ_SINGLE_STEP_EN
    .step   (step_a),
`endif
    .bus    (ifa.master),
    .state  (state_a),
    .halted (halted_a)
  );

  proc_sequencer #(.TICK_DIV(4), .PC_W(3)) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .run    (run_b),
`ifdef PROC_SEQ_SINGLE_STEP_EN
    .step   (step_b),
`endif
    .bus    (ifb.master),
    .state  (state_b),
    .halted (halted_b)
  );

  // Synchronous ROMs: data follows address by one clock.
  always @(posedge clk) begin
    ifa.instruction <= rom_a[ifa.address];
    ifb.instruction <= rom_b[ifb.address];
    cyc_a <= rst_a ? cyc_a + 1 : 0;
    cyc_b <= rst_b ? cyc_b + 1 : 0;
  end

  task automatic pe(input bit d, input int c, input bit l, input logic [1:0] wa,
                    input logic [1:0] ws, input logic [2:0] ad);
    ev_t e;
    e.dut = d; e.cyc = c; e.load = l; e.waddr = wa; e.wsel = ws; e.addr = ad;
    eq.push_back(e);
  endtask

  task automatic pp(input bit d, input int c, input int f, input logic [7:0] v);
    probe_t p;
    p.dut = d; p.cyc = c; p.field = f; p.val = v;
    pq.push_back(p);
  endtask

  function automatic int cyc_of(input bit d);
    return d ? cyc_b : cyc_a;
  endfunction

  function automatic logic [7:0] peek(input bit d, input int f);
    logic [7:0] r;
    case (f)
      F_STATE: r = d ? {5'd0, state_b} : {5'd0, state_a};
      F_ADDR:  r = d ? {5'd0, ifb.address} : {5'd0, ifa.address};
      F_HALT:  r = d ? {7'd0, halted_b} : {7'd0, halted_a};
      default: r = d ? ifb.ir : ifa.ir;
    endcase
    return r;
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_STATE: return "state";
      F_ADDR:  return "address";
      F_HALT:  return "halted";
      default: return "ir";
    endcase
  endfunction

  task automatic check_ev(input bit d, input logic we, input logic ld,
                          input logic [1:0] wa, input logic [1:0] ws, input logic [2:0] ad);
    ev_t e;
    if (we && ld) begin
      total++; bad++;
      $display("FAIL excl dut%0d cyc%0d: rf_we and result_load both high", d, cyc_of(d));
    end
    while (eq.size() > 0 && eq[0].dut == d && eq[0].cyc < cyc_of(d)) begin
      e = eq.pop_front();
      total++; bad++;
      $display("FAIL missed_pulse dut%0d: got none by cyc%0d want pulse at cyc%0d load=%0d",
               d, cyc_of(d), e.cyc, e.load);
    end
    if (we || ld) begin
      total++;
      if (eq.size() == 0 || eq[0].dut != d || eq[0].cyc != cyc_of(d)) begin
        bad++;
        $display("FAIL unexpected_pulse dut%0d cyc%0d: got we=%0d load=%0d addr=%0d want none",
                 d, cyc_of(d), we, ld, ad);
      end else begin
        e = eq.pop_front();
        if (e.load != ld || e.addr != ad || (!e.load && (e.waddr != wa || e.wsel != ws))) begin
          bad++;
          $display("FAIL pulse dut%0d cyc%0d: got load=%0d waddr=%0d wsel=%0d addr=%0d want load=%0d waddr=%0d wsel=%0d addr=%0d",
                   d, cyc_of(d), ld, wa, ws, ad, e.load, e.waddr, e.wsel, e.addr);
        end
      end
    end
  endtask

  // Monitor: pops expected pulses and level probes as the DUTs reach them.
  always @(negedge clk) begin
    probe_t p;
    logic [7:0] got;
    while (pq.size() > 0 && pq[0].cyc <= cyc_of(pq[0].dut)) begin
      p = pq.pop_front();
      got = peek(p.dut, p.field);
      total++;
      if (p.cyc != cyc_of(p.dut) || got !== p.val) begin
        bad++;
        $display("FAIL %s dut%0d cyc%0d (now cyc%0d): got %h want %h",
                 fname(p.field), p.dut, p.cyc, cyc_of(p.dut), got, p.val);
      end
    end
    check_ev(1'b0, ifa.rf_we, ifa.result_load, ifa.rf_waddr, ifa.rf_wsel, ifa.address);
    check_ev(1'b1, ifb.rf_we, ifb.result_load, ifb.rf_waddr, ifb.rf_wsel, ifb.address);
    if (done && !finished) begin
      finished = 1'b1;
      total++;
      if (eq.size() != 0 || pq.size() != 0) begin
        bad++;
        $display("FAIL leftover: got %0d pulses %0d probes pending want 0 0", eq.size(), pq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    // Program A: LDI r1, ADD, OUT, JMP 5, -, ADD, ADD, ADD (slot 7 wraps to 0).
    rom_a[0] = 8'hC5; rom_a[1] = 8'h44; rom_a[2] = 8'h01; rom_a[3] = 8'h85;
    rom_a[4] = 8'h00; rom_a[5] = 8'h40; rom_a[6] = 8'h40; rom_a[7] = 8'h40;
    for (int i = 0; i < 8; i++) rom_b[i] = 8'h40;
    run_a = 1'b1;
    pp(0, 0, F_STATE, 8'd0); pp(0, 0, F_ADDR, 8'd0); pp(0, 0, F_IR, 8'd0);
    pp(0, 0, F_HALT, 8'd0);  pp(0, 1, F_STATE, 8'd1); pp(0, 3, F_STATE, 8'd3);
    pp(0, 4, F_ADDR, 8'd1);  pp(0, 9, F_IR, 8'h01);  pp(0, 12, F_ADDR, 8'd3);
    pp(0, 12, F_IR, 8'h85);  pp(0, 13, F_ADDR, 8'd5); pp(0, 22, F_ADDR, 8'd0);
    pe(0, 3, 0, 2'd1, 2'd1, 3'd0);  pe(0, 6, 0, 2'd1, 2'd0, 3'd1);
    pe(0, 9, 1, 2'd0, 2'd0, 3'd2);  pe(0, 15, 0, 2'd0, 2'd0, 3'd5);
    pe(0, 18, 0, 2'd0, 2'd0, 3'd6); pe(0, 21, 0, 2'd0, 2'd0, 3'd7);
    pe(0, 24, 0, 2'd1, 2'd1, 3'd0);
    @(negedge clk); #2 rst_a = 1'b1;
    repeat (25) @(negedge clk);
    #2 rst_a = 1'b0;

    // Program A2: LDI r1 then HALT; address must freeze at 1.
    rom_a[0] = 8'hC9; rom_a[1] = 8'hA0;
    pp(0, 0, F_STATE, 8'd0); pp(0, 5, F_IR, 8'hC9);   pp(0, 6, F_STATE, 8'd3);
    pp(0, 7, F_STATE, 8'd4); pp(0, 7, F_HALT, 8'd1);  pp(0, 7, F_ADDR, 8'd1);
    pp(0, 7, F_IR, 8'hA0);   pp(0, 107, F_STATE, 8'd4); pp(0, 107, F_ADDR, 8'd1);
    pp(0, 107, F_HALT, 8'd1);
    pe(0, 3, 0, 2'd1, 2'd1, 3'd0);
    @(negedge clk); #2 rst_a = 1'b1;
    repeat (108) @(negedge clk);
    #2 rst_a = 1'b0; run_a = 1'b0;
    pp(0, 0, F_STATE, 8'd0); pp(0, 0, F_HALT, 8'd0); pp(0, 0, F_ADDR, 8'd0);
    @(negedge clk);

    // DUT B, TICK_DIV=4: run dropped during DECODE, one ADD completes then IDLE.
    run_b = 1'b1;
    pp(1, 0, F_STATE, 8'd0);  pp(1, 3, F_STATE, 8'd0);  pp(1, 4, F_STATE, 8'd1);
    pp(1, 8, F_STATE, 8'd2);  pp(1, 12, F_STATE, 8'd3); pp(1, 16, F_STATE, 8'd0);
    pp(1, 16, F_ADDR, 8'd1);  pp(1, 24, F_STATE, 8'd0); pp(1, 24, F_ADDR, 8'd1);
    pe(1, 15, 0, 2'd0, 2'd0, 3'd0);
    #2 rst_b = 1'b1;
    repeat (9) @(negedge clk);
    #2 run_b = 1'b0;
    repeat (15) @(negedge clk);
`ifdef PROC_SEQ_SINGLE_STEP_EN
    #2 rst_b = 1'b0;
    pp(1, 0, F_STATE, 8'd0);  pp(1, 8, F_STATE, 8'd3);  pp(1, 9, F_STATE, 8'd0);
    pp(1, 9, F_ADDR, 8'd1);   pp(1, 16, F_STATE, 8'd0); pp(1, 16, F_ADDR, 8'd2);
    pp(1, 30, F_ADDR, 8'd2);
    pe(1, 8, 0, 2'd0, 2'd0, 3'd0); pe(1, 15, 0, 2'd0, 2'd0, 3'd1);
    @(negedge clk); #2 rst_b = 1'b1;
    repeat (5) @(negedge clk);
    #2 step_b = 1'b1;
    repeat (5) @(negedge clk);
    #2 step_b = 1'b0;
    repeat (2) @(negedge clk);
    #2 step_b = 1'b1;
    repeat (18) @(negedge clk);
`endif
    #2 done = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL timeout: got no summary want summary");
    $fatal(1);
  end
endmodule
`default_nettype wire
